// File: rtl/udma_hyper_reg_if_multi.sv
// udma_hyper_reg_if_multi
// HyperBus uDMA configuration register interface with per-device timing banks.
// Each device bank exists twice: a shadow copy written over the cfg bus and an
// active copy driven to the controller. A COMMIT request copies every shadow
// bank to active in one cycle, but only once the controller reports idle, so
// timing never changes in the middle of a transaction. A transaction-ID
// allocator hands out the lowest free channel on a read of TRANS_ID_ALLOC and
// reserves it until the channel goes busy, is released, or times out.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   cfg_data_i/addr_i/valid_i/rwn_i  cfg bus access (word address, 1=read)
//   cfg_data_o                       combinational read data
//   cfg_ready_o                      always ready
//   ctrl_idle_i                      controller has no transaction in flight
//   busy_vec_i                       per-channel busy flags
//   cfg_t_*_o, cfg_en_*, cfg_mem_sel_o  active timing banks, bank d packed at d*W
//   cfg_page_bound_o                 page boundary code
//   cfg_rx_dest_o, cfg_tx_dest_o     uDMA destinations
//   rsv_vec_o                        reserved transaction IDs
//   commit_pending_o                 commit requested but not yet applied
module udma_hyper_reg_if_multi #(
  parameter int unsigned NB_CH           = 4,
  parameter int unsigned NB_DEV          = 2,
  parameter int unsigned DELAY_BIT_WIDTH = 3,
  parameter int unsigned RSV_TIMEOUT     = 255,
  parameter int unsigned DEST_SIZE       = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [31:0]                       cfg_data_i,
  input  logic [4:0]                        cfg_addr_i,
  input  logic                              cfg_valid_i,
  input  logic                              cfg_reg_rwn_i,
  output logic [31:0]                       cfg_data_o,
  output logic                              cfg_ready_o,
  input  logic                              ctrl_idle_i,
  input  logic [NB_CH-1:0]                  busy_vec_i,
  output logic [NB_DEV*5-1:0]               cfg_t_latency_access_o,
  output logic [NB_DEV-1:0]                 cfg_en_latency_additional_o,
  output logic [NB_DEV*32-1:0]              cfg_t_cs_max_o,
  output logic [NB_DEV*32-1:0]              cfg_t_read_write_recovery_o,
  output logic [NB_DEV*DELAY_BIT_WIDTH-1:0] cfg_t_rwds_delay_line_o,
  output logic [NB_DEV*4-1:0]               cfg_t_variable_latency_check_o,
  output logic [NB_DEV*2-1:0]               cfg_mem_sel_o,
  output logic [2:0]                        cfg_page_bound_o,
  output logic [DEST_SIZE-1:0]              cfg_rx_dest_o,
  output logic [DEST_SIZE-1:0]              cfg_tx_dest_o,
  output logic [NB_CH-1:0]                  rsv_vec_o,
  output logic                              commit_pending_o
);

  localparam int unsigned DSW = (NB_DEV > 1) ? $clog2(NB_DEV) : 1;
  localparam int unsigned CHW = (NB_CH > 1) ? $clog2(NB_CH) : 1;
  localparam int unsigned CW  = $clog2(RSV_TIMEOUT + 1);

  localparam logic [4:0] A_PAGE_BOUND = 5'd0;
  localparam logic [4:0] A_DEV_SEL    = 5'd1;
  localparam logic [4:0] A_T_LAT      = 5'd2;
  localparam logic [4:0] A_EN_LAT     = 5'd3;
  localparam logic [4:0] A_CS_MAX     = 5'd4;
  localparam logic [4:0] A_RW_REC     = 5'd5;
  localparam logic [4:0] A_RWDS_DLY   = 5'd6;
  localparam logic [4:0] A_VARI_LAT   = 5'd7;
  localparam logic [4:0] A_MEM_SEL    = 5'd8;
  localparam logic [4:0] A_ID_ALLOC   = 5'd9;
  localparam logic [4:0] A_DEST       = 5'd10;
  localparam logic [4:0] A_COMMIT     = 5'd11;
  localparam logic [4:0] A_ID_RELEASE = 5'd12;

  typedef struct packed {
    logic [4:0]                 t_lat;
    logic                       en_lat;
    logic [31:0]                cs_max;
    logic [31:0]                rw_rec;
    logic [DELAY_BIT_WIDTH-1:0] rwds;
    logic [3:0]                 vari;
    logic [1:0]                 mem_sel;
  } bank_t;

  localparam bank_t BANK_RST = '{
    t_lat:   5'd6,
    en_lat:  1'b1,
    cs_max:  32'd665,
    rw_rec:  32'd6,
    rwds:    DELAY_BIT_WIDTH'(2),
    vari:    4'd3,
    mem_sel: 2'd0
  };

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } commit_state_t;

  commit_state_t        state_q;
  bank_t                shadow_q [NB_DEV];
  bank_t                active_q [NB_DEV];
  logic [2:0]           page_bound_q;
  logic [DSW-1:0]       dev_sel_q;
  logic                 dev_sel_oor_q;
  logic [DEST_SIZE-1:0] rx_dest_q;
  logic [DEST_SIZE-1:0] tx_dest_q;
  logic [NB_CH-1:0]     rsv_q;
  logic [CW-1:0]        cnt_q [NB_CH];

  logic                 wr;
  logic                 rd;
  logic                 bank_ok;
  logic                 commit_wr;
  logic [NB_CH-1:0]     release_mask;
  logic                 free_found;
  logic [CHW-1:0]       free_idx;
  logic                 claim;
  bank_t                sel_bank;

  assign wr        = cfg_valid_i & ~cfg_reg_rwn_i;
  assign rd        = cfg_valid_i & cfg_reg_rwn_i;
  assign commit_wr = wr && (cfg_addr_i == A_COMMIT) && cfg_data_i[0];
  assign release_mask = (wr && (cfg_addr_i == A_ID_RELEASE)) ? cfg_data_i[NB_CH-1:0] : '0;
  // DEV_SEL keeps only DSW bits, so an out-of-range selection is flagged from
  // the full written value; otherwise a value like 5 would alias onto bank 1.
  assign bank_ok   = ~dev_sel_oor_q;
  assign sel_bank  = shadow_q[dev_sel_q];
  assign claim     = rd && (cfg_addr_i == A_ID_ALLOC) && free_found;

  // Lowest channel that is neither busy nor reserved; scanning downward lets
  // the lowest index overwrite higher ones.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = NB_CH; i > 0; i--) begin
      if (!busy_vec_i[i-1] && !rsv_q[i-1]) begin
        free_found = 1'b1;
        free_idx   = CHW'(i - 1);
      end
    end
  end

  always_comb begin
    cfg_data_o = '0;
    case (cfg_addr_i)
      A_PAGE_BOUND: cfg_data_o[2:0] = page_bound_q;
      A_DEV_SEL:    cfg_data_o[DSW-1:0] = dev_sel_q;
      A_T_LAT:      if (bank_ok) cfg_data_o[4:0] = sel_bank.t_lat;
      A_EN_LAT:     if (bank_ok) cfg_data_o[0] = sel_bank.en_lat;
      A_CS_MAX:     if (bank_ok) cfg_data_o = sel_bank.cs_max;
      A_RW_REC:     if (bank_ok) cfg_data_o = sel_bank.rw_rec;
      A_RWDS_DLY:   if (bank_ok) cfg_data_o[DELAY_BIT_WIDTH-1:0] = sel_bank.rwds;
      A_VARI_LAT:   if (bank_ok) cfg_data_o[3:0] = sel_bank.vari;
      A_MEM_SEL:    if (bank_ok) cfg_data_o[1:0] = sel_bank.mem_sel;
      A_ID_ALLOC: begin
        if (free_found) begin
          cfg_data_o[31]      = 1'b1;
          cfg_data_o[CHW-1:0] = free_idx;
        end
      end
      A_DEST: begin
        cfg_data_o[0+:DEST_SIZE] = rx_dest_q;
        cfg_data_o[8+:DEST_SIZE] = tx_dest_q;
      end
      A_COMMIT:     cfg_data_o[0] = (state_q == PEND);
      default:      cfg_data_o = '0;
    endcase
  end

  // Directly written configuration and shadow banks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      page_bound_q  <= '0;
      dev_sel_q     <= '0;
      dev_sel_oor_q <= 1'b0;
      rx_dest_q     <= '0;
      tx_dest_q     <= '0;
      for (int unsigned d = 0; d < NB_DEV; d++) shadow_q[d] <= BANK_RST;
    end else if (wr) begin
      case (cfg_addr_i)
        A_PAGE_BOUND: page_bound_q <= cfg_data_i[2:0];
        A_DEV_SEL: begin
          dev_sel_q     <= cfg_data_i[DSW-1:0];
          dev_sel_oor_q <= (cfg_data_i >= 32'(NB_DEV));
        end
        A_T_LAT:      if (bank_ok) shadow_q[dev_sel_q].t_lat   <= cfg_data_i[4:0];
        A_EN_LAT:     if (bank_ok) shadow_q[dev_sel_q].en_lat  <= cfg_data_i[0];
        A_CS_MAX:     if (bank_ok) shadow_q[dev_sel_q].cs_max  <= cfg_data_i;
        A_RW_REC:     if (bank_ok) shadow_q[dev_sel_q].rw_rec  <= cfg_data_i;
        A_RWDS_DLY:   if (bank_ok) shadow_q[dev_sel_q].rwds    <= cfg_data_i[DELAY_BIT_WIDTH-1:0];
        A_VARI_LAT:   if (bank_ok) shadow_q[dev_sel_q].vari    <= cfg_data_i[3:0];
        A_MEM_SEL:    if (bank_ok) shadow_q[dev_sel_q].mem_sel <= cfg_data_i[1:0];
        A_DEST: begin
          rx_dest_q <= cfg_data_i[0+:DEST_SIZE];
          tx_dest_q <= cfg_data_i[8+:DEST_SIZE];
        end
        default: ;
      endcase
    end
  end

  // Commit FSM. The copy samples the shadow registers before this cycle's
  // write lands, so a shadow write in the apply cycle stays in shadow only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      for (int unsigned d = 0; d < NB_DEV; d++) active_q[d] <= BANK_RST;
    end else begin
      case (state_q)
        IDLE: if (commit_wr) state_q <= PEND;
        PEND: begin
          if (ctrl_idle_i) begin
            for (int unsigned d = 0; d < NB_DEV; d++) active_q[d] <= shadow_q[d];
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reservation tracking. The counter holds the cycles elapsed since the set,
  // so reaching RSV_TIMEOUT-1 before an edge means the flag drops exactly
  // RSV_TIMEOUT cycles after it rose. A claim overrides a same-cycle release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsv_q <= '0;
      for (int unsigned i = 0; i < NB_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_CH; i++) begin
        if (claim && (free_idx == CHW'(i))) begin
          rsv_q[i] <= 1'b1;
          cnt_q[i] <= '0;
        end else if (rsv_q[i]) begin
          if (busy_vec_i[i] || release_mask[i] || (cnt_q[i] == CW'(RSV_TIMEOUT - 1))) begin
            rsv_q[i] <= 1'b0;
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    cfg_t_latency_access_o         = '0;
    cfg_en_latency_additional_o    = '0;
    cfg_t_cs_max_o                 = '0;
    cfg_t_read_write_recovery_o    = '0;
    cfg_t_rwds_delay_line_o        = '0;
    cfg_t_variable_latency_check_o = '0;
    cfg_mem_sel_o                  = '0;
    for (int unsigned d = 0; d < NB_DEV; d++) begin
      cfg_t_latency_access_o[d*5+:5]                             = active_q[d].t_lat;
      cfg_en_latency_additional_o[d]                             = active_q[d].en_lat;
      cfg_t_cs_max_o[d*32+:32]                                   = active_q[d].cs_max;
      cfg_t_read_write_recovery_o[d*32+:32]                      = active_q[d].rw_rec;
      cfg_t_rwds_delay_line_o[d*DELAY_BIT_WIDTH+:DELAY_BIT_WIDTH] = active_q[d].rwds;
      cfg_t_variable_latency_check_o[d*4+:4]                     = active_q[d].vari;
      cfg_mem_sel_o[d*2+:2]                                      = active_q[d].mem_sel;
    end
  end

  assign cfg_ready_o      = 1'b1;
  assign cfg_page_bound_o = page_bound_q;
  assign cfg_rx_dest_o    = rx_dest_q;
  assign cfg_tx_dest_o    = tx_dest_q;
  assign rsv_vec_o        = rsv_q;
  assign commit_pending_o = (state_q == PEND);

endmodule
